bus_turn_ctrl: RTL and testbench
================================

BUS_TURN_CTRL -- requirements
Module: bus_turn_ctrl

Interface
REQ-001 Parameter TURN_CYC, default 2, turnaround gap cycles with both sides undriven; legal range 1..15.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per ownership; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_a  input  1  side A requests to drive the shared bidirectional net; level, held until granted or withdrawn.
REQ-006 req_b  input  1  side B request; same semantics as req_a.
REQ-007 done_a  input  1  side A releases the net; honoured only while grant_a=1.
REQ-008 done_b  input  1  side B release; honoured only while grant_b=1.
REQ-009 grant_a  output  1  side A owns the net.
REQ-010 grant_b  output  1  side B owns the net.
REQ-011 oe_a  output  1  tri-state enable for side A driver onto the shared net.
REQ-012 oe_b  output  1  tri-state enable for side B driver.
REQ-013 turn  output  1  turnaround in progress; neither side may drive.
REQ-014 busy  output  1  any grant active or turnaround in progress.

Function
REQ-015 States IDLE, GNT_A, GNT_B, TURN; all outputs decoded from registered state, no combinational input-to-output path.
REQ-016 grant_a=oe_a=1 iff GNT_A; grant_b=oe_b=1 iff GNT_B; turn=1 iff TURN; busy=1 iff state!=IDLE.
REQ-017 oe_a and oe_b shall never both be 1 in any cycle.
REQ-018 IDLE: only req_a -> GNT_A next edge; only req_b -> GNT_B; neither -> stay IDLE.
REQ-019 IDLE, both requesting: grant the side not equal to last_owner; last_owner resets to B, so A wins the first tie.
REQ-020 On entering GNT_A or GNT_B: last_owner updates to that side; hold counter loads 1.
REQ-021 GNT_x: hold counter increments each cycle; release when done_x=1 or hold counter=MAX_HOLD.
REQ-022 Release edge: next state TURN; turnaround counter loads 1.
REQ-023 Withdrawal of req_x while in GNT_x does not release; only done_x or timeout releases.
REQ-024 done for the non-granted side is ignored in all states; done_x in IDLE or TURN is ignored.
REQ-025 TURN lasts exactly TURN_CYC cycles, then IDLE; requests are not sampled during TURN.
REQ-026 A re-grant of the same side also passes through TURN and IDLE; no back-to-back grant without a gap.
REQ-027 Minimum gap between a falling oe_x and any rising oe_y is TURN_CYC+1 cycles (TURN plus one IDLE cycle).
REQ-028 done_x and timeout in the same cycle: single release, identical to REQ-022.
REQ-029 Counters are saturation-free by construction; widths are ceil(log2(MAX_HOLD+1)) and 4 bits.

Reset
REQ-030 rst_n=0 forces IDLE, last_owner=B, both counters 0, all outputs 0, immediately without a clock edge.
REQ-031 rst_n deassertion is synchronised internally with a 2-flop release; the first arbitration occurs no earlier than the 2nd edge after deassertion.
REQ-032 Reset during GNT_x drops oe_x asynchronously; after reset release no turnaround is owed, and arbitration starts from IDLE.

Verification (TURN_CYC=2, MAX_HOLD=8)
REQ-033 Reset assert with req_a=req_b=1 -> all outputs 0; after release both sync edges elapse, then grant_a=1 (tie, A first).
REQ-034 req_a alone, sampled at edge k; done_a pulsed at edge k+3 -> grant_a/oe_a high edges k+1..k+3, turn high for 2 cycles, busy=0 thereafter.
REQ-035 req_a held, no done -> grant_a high exactly 8 cycles, turn 2 cycles, 1 IDLE cycle, grant_a again; req_b joins in IDLE -> B wins (last_owner=A).
REQ-036 Both requesting continuously with done each grant -> alternates A,B,A,B; oe_a&oe_b never 1; every oe gap is >=3 cycles.
REQ-037 done_b pulsed while grant_a=1 -> no effect; grant_a persists until done_a or timeout.
REQ-038 rst_n asserted mid-GNT_B between edges -> oe_b, grant_b, busy fall to 0 before the next clk edge.

Source files
------------

// File: rtl/bus_turn_if.sv
// Handshake and tri-state control bundle between the two bus sides and the
// turnaround controller.
interface bus_turn_if;
  logic req_a;
  logic req_b;
  logic done_a;
  logic done_b;
  logic grant_a;
  logic grant_b;
  logic oe_a;
  logic oe_b;
  logic turn;
  logic busy;

  modport master (
    input  req_a, req_b, done_a, done_b,
    output grant_a, grant_b, oe_a, oe_b, turn, busy
  );

  modport slave (
    output req_a, req_b, done_a, done_b,
    input  grant_a, grant_b, oe_a, oe_b, turn, busy
  );
endinterface

// File: rtl/bus_turn_ctrl.sv
// Ownership arbiter for a shared bidirectional net: grants one side at a time
// and inserts an undriven turnaround gap between every pair of ownerships.
module bus_turn_ctrl #(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  bus_turn_if.master bus
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD);
  localparam logic [3:0]        TURN_LAST = 4'(TURN_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  state_t            state_r;
  state_t            state_nxt_s;
  owner_t            last_owner_r;
  owner_t            last_owner_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_nxt_s;
  logic [3:0]        turn_cnt_r;
  logic [3:0]        turn_cnt_nxt_s;
  logic [1:0]        rst_sync_r;
  logic              arb_en_s;
  logic              grant_a_r;
  logic              grant_b_r;
  logic              turn_r;
  logic              busy_r;

  // Reset release synchroniser: arbitration stays frozen until two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign arb_en_s = rst_sync_r[1];

  // State, ownership history and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_owner_r <= OWN_B;
      hold_cnt_r   <= HOLD_ZERO;
      turn_cnt_r   <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      turn_cnt_r   <= turn_cnt_nxt_s;
    end
  end

  // Next-state and counter decode; hold counter tops out at MAX_HOLD, where it releases.
  always_comb begin
    state_nxt_s      = state_r;
    last_owner_nxt_s = last_owner_r;
    hold_cnt_nxt_s   = hold_cnt_r;
    turn_cnt_nxt_s   = turn_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_en_s && (bus.req_a || bus.req_b)) begin
          // A wins if alone, or on a tie when B owned the net last.
          if (bus.req_a && (!bus.req_b || (last_owner_r == OWN_B))) begin
            state_nxt_s      = ST_GNT_A;
            last_owner_nxt_s = OWN_A;
          end else begin
            state_nxt_s      = ST_GNT_B;
            last_owner_nxt_s = OWN_B;
          end
          hold_cnt_nxt_s = HOLD_ONE;
        end else begin
          hold_cnt_nxt_s = HOLD_ZERO;
        end
      end
      ST_GNT_A: begin
        if (bus.done_a || (hold_cnt_r == HOLD_LAST)) begin
          state_nxt_s    = ST_TURN;
          hold_cnt_nxt_s = HOLD_ZERO;
          turn_cnt_nxt_s = 4'd1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      ST_GNT_B: begin
        if (bus.done_b || (hold_cnt_r == HOLD_LAST)) begin
          state_nxt_s    = ST_TURN;
          hold_cnt_nxt_s = HOLD_ZERO;
          turn_cnt_nxt_s = 4'd1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      ST_TURN: begin
        if (turn_cnt_r == TURN_LAST) begin
          state_nxt_s    = ST_IDLE;
          turn_cnt_nxt_s = 4'd0;
        end else begin
          turn_cnt_nxt_s = turn_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        hold_cnt_nxt_s = HOLD_ZERO;
        turn_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Outputs registered from the next state so they change exactly with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_a_r <= 1'b0;
      grant_b_r <= 1'b0;
      turn_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      grant_a_r <= (state_nxt_s == ST_GNT_A);
      grant_b_r <= (state_nxt_s == ST_GNT_B);
      turn_r    <= (state_nxt_s == ST_TURN);
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.grant_a = grant_a_r;
  assign bus.oe_a    = grant_a_r;
  assign bus.grant_b = grant_b_r;
  assign bus.oe_b    = grant_b_r;
  assign bus.turn    = turn_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_bus_turn_ctrl.sv
// Directed bench for bus_turn_ctrl (TURN_CYC=2, MAX_HOLD=8).
module tb_bus_turn_ctrl;
  // Output vector order: {grant_a, grant_b, oe_a, oe_b, turn, busy}
  localparam logic [5:0] ID = 6'b000000;
  localparam logic [5:0] GA = 6'b101001;
  localparam logic [5:0] GB = 6'b010101;
  localparam logic [5:0] TN = 6'b000011;

  logic       clk;
  logic       rst_n;
  logic [5:0] obs;
  int         total;
  int         bad;

  bus_turn_if bif();

  bus_turn_ctrl #(.TURN_CYC(2), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  assign obs = {bif.grant_a, bif.grant_b, bif.oe_a, bif.oe_b, bif.turn, bif.busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    bif.req_a = 1'b1; bif.req_b = 1'b1; bif.done_a = 1'b0; bif.done_b = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if (obs !== ID) begin bad++; $display("FAIL rst_async got=%b exp=%b", obs, ID); end
    tick; tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL rst_held got=%b exp=%b", obs, ID); end
    rst_n = 1'b1;
    tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL rst_sync1 got=%b exp=%b", obs, ID); end
    tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL rst_sync2 got=%b exp=%b", obs, ID); end
    tick;
    total++; if (obs !== GA) begin bad++; $display("FAIL rst_tie_a got=%b exp=%b", obs, GA); end
    bif.req_a = 1'b0; bif.req_b = 1'b0; bif.done_a = 1'b1;
    tick;
    bif.done_a = 1'b0;
    total++; if (obs !== TN) begin bad++; $display("FAIL rst_release got=%b exp=%b", obs, TN); end
    tick; tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL rst_idle got=%b exp=%b", obs, ID); end
  endtask

  task automatic test_done_release;
    logic [5:0] seq [5];
    seq = '{GA, GA, TN, TN, ID};
    bif.req_a = 1'b1;
    tick;
    total++; if (obs !== GA) begin bad++; $display("FAIL done_grant got=%b exp=%b", obs, GA); end
    bif.req_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bif.done_a = (i == 2);
      tick;
      bif.done_a = 1'b0;
      total++; if (obs !== seq[i]) begin bad++; $display("FAIL done_seq[%0d] got=%b exp=%b", i, obs, seq[i]); end
    end
  endtask

  task automatic test_timeout;
    bif.req_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      total++; if (obs !== GA) begin bad++; $display("FAIL hold[%0d] got=%b exp=%b", i, obs, GA); end
    end
    tick;
    total++; if (obs !== TN) begin bad++; $display("FAIL timeout_turn1 got=%b exp=%b", obs, TN); end
    tick;
    total++; if (obs !== TN) begin bad++; $display("FAIL timeout_turn2 got=%b exp=%b", obs, TN); end
    tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL timeout_idle got=%b exp=%b", obs, ID); end
    tick;
    total++; if (obs !== GA) begin bad++; $display("FAIL regrant_a got=%b exp=%b", obs, GA); end
    bif.done_a = 1'b1;
    tick;
    bif.done_a = 1'b0;
    bif.req_b = 1'b1;
    total++; if (obs !== TN) begin bad++; $display("FAIL regrant_turn got=%b exp=%b", obs, TN); end
    tick; tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL regrant_idle got=%b exp=%b", obs, ID); end
    tick;
    total++; if (obs !== GB) begin bad++; $display("FAIL tie_b_wins got=%b exp=%b", obs, GB); end
    bif.req_a = 1'b0; bif.req_b = 1'b0; bif.done_b = 1'b1;
    tick;
    bif.done_b = 1'b0;
    tick; tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL timeout_end got=%b exp=%b", obs, ID); end
  endtask

  task automatic test_alternate;
    logic exp_a;
    logic prev_any;
    int   gap;
    int   grants;
    exp_a = 1'b1; prev_any = 1'b0; gap = 0; grants = 0;
    bif.req_a = 1'b1; bif.req_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick;
      total++; if (bif.oe_a && bif.oe_b) begin bad++; $display("FAIL alt_overlap got=11 exp=not 11 at step %0d", i); end
      if ((bif.oe_a || bif.oe_b) && !prev_any) begin
        total++; if (bif.oe_a !== exp_a) begin bad++; $display("FAIL alt_order got oe_a=%b exp=%b", bif.oe_a, exp_a); end
        if (grants > 0) begin
          total++; if (gap != 3) begin bad++; $display("FAIL alt_gap got=%0d exp=3", gap); end
        end
        exp_a = ~exp_a;
        grants++;
        gap = 0;
      end else if (!(bif.oe_a || bif.oe_b)) begin
        gap++;
      end
      prev_any = bif.oe_a || bif.oe_b;
      bif.done_a = bif.grant_a;
      bif.done_b = bif.grant_b;
    end
    total++; if (grants != 6) begin bad++; $display("FAIL alt_count got=%0d exp=6", grants); end
    bif.req_a = 1'b0; bif.req_b = 1'b0; bif.done_a = 1'b0; bif.done_b = 1'b0;
    tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL alt_end got=%b exp=%b", obs, ID); end
  endtask

  task automatic test_foreign_done;
    bif.done_a = 1'b1;
    tick;
    bif.done_a = 1'b0;
    total++; if (obs !== ID) begin bad++; $display("FAIL done_in_idle got=%b exp=%b", obs, ID); end
    bif.req_a = 1'b1;
    tick;
    total++; if (obs !== GA) begin bad++; $display("FAIL foreign_grant got=%b exp=%b", obs, GA); end
    bif.req_a = 1'b0;
    bif.done_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (obs !== GA) begin bad++; $display("FAIL foreign_done[%0d] got=%b exp=%b", i, obs, GA); end
    end
    bif.done_b = 1'b0; bif.done_a = 1'b1;
    tick;
    bif.done_a = 1'b0;
    total++; if (obs !== TN) begin bad++; $display("FAIL foreign_release got=%b exp=%b", obs, TN); end
    tick; tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL foreign_end got=%b exp=%b", obs, ID); end
  endtask

  task automatic test_reset_mid;
    bif.req_b = 1'b1;
    tick;
    total++; if (obs !== GB) begin bad++; $display("FAIL mid_grant_b got=%b exp=%b", obs, GB); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (obs !== ID) begin bad++; $display("FAIL mid_rst_async got=%b exp=%b", obs, ID); end
    bif.req_a = 1'b1;
    #1 rst_n = 1'b1;
    tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL mid_sync1 got=%b exp=%b", obs, ID); end
    tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL mid_sync2 got=%b exp=%b", obs, ID); end
    tick;
    total++; if (obs !== GA) begin bad++; $display("FAIL mid_tie_a got=%b exp=%b", obs, GA); end
    bif.req_a = 1'b0; bif.req_b = 1'b0; bif.done_a = 1'b1;
    tick;
    bif.done_a = 1'b0;
    tick; tick;
    total++; if (obs !== ID) begin bad++; $display("FAIL mid_end got=%b exp=%b", obs, ID); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_done_release;
    test_timeout;
    test_alternate;
    test_foreign_done;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
